// File: rtl/pid_pkg.sv
// Shared state encoding, default widths and the saturation range helper
// used by the PID sequencer and its integrator.
package pid_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ERR   = 3'd1,
      MUL_P = 3'd2,
      MUL_I = 3'd3,
      MUL_D = 3'd4,
      SUM   = 3'd5
   } pid_state_e;

   localparam int PID_DATA_WIDTH = 14;
   localparam int PID_OUT_WIDTH  = 2 * PID_DATA_WIDTH + 1;
   localparam int ERROR_WIDTH    = PID_DATA_WIDTH + 1;
   localparam int DELTA_WIDTH    = PID_DATA_WIDTH + 2;
   localparam int SUM_WIDTH      = PID_OUT_WIDTH + 2;

   // Range test for saturating v into a signed w-bit result: {above_max, below_min}.
   function automatic logic [1:0] sat_flags(input logic signed [63:0] v, input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
      lo = -hi - 64'sd1;
      sat_flags = {v > hi, v < lo};
   endfunction

endpackage

// File: rtl/pid_sat_acc.sv
// Saturating signed integrator with a clear input that overrides any add.
module pid_sat_acc
   import pid_pkg::*;
#(
   parameter int ACC_WIDTH = PID_OUT_WIDTH,
   parameter int ADD_WIDTH = PID_OUT_WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 add_en,
   input  logic [ADD_WIDTH-1:0] add_val,
   output logic [ACC_WIDTH-1:0] acc
);

   localparam int W = ACC_WIDTH + 2;
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic signed [W-1:0]         sum_s;
   logic [1:0]                  flags_s;

   // Next integrator value: clear wins, otherwise clamp the widened sum.
   always_comb begin
      sum_s   = W'(acc_q) + W'($signed(add_val));
      flags_s = sat_flags(64'(sum_s), ACC_WIDTH);
      acc_d   = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (add_en) begin
         if (flags_s[1]) begin
            acc_d = ACC_MAX;
         end else if (flags_s[0]) begin
            acc_d = ACC_MIN;
         end else begin
            acc_d = sum_s[ACC_WIDTH-1:0];
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Integrator register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/pid_sequencer.sv
// Time-multiplexed PID engine sharing one signed multiplier across P, I and D.
// Define PID_DERIV_EN to include the derivative path (MUL_D state, prev_error).
module pid_sequencer
   import pid_pkg::*;
#(
   parameter int DATA_WIDTH = PID_DATA_WIDTH,
   parameter int OUT_WIDTH  = 2 * DATA_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] set_point,
   input  logic [DATA_WIDTH-1:0] p_coef,
   input  logic [DATA_WIDTH-1:0] i_coef,
   input  logic [DATA_WIDTH-1:0] d_coef,
   input  logic                  int_clear,
   output logic                  busy,
   output logic [OUT_WIDTH-1:0]  data_out,
   output logic                  out_valid,
   output logic                  overrun
);

   localparam int E_W  = DATA_WIDTH + 1;
   localparam int DL_W = DATA_WIDTH + 2;
   localparam int PR_W = DL_W + DATA_WIDTH;
   localparam int S_W  = OUT_WIDTH + 2;
   localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   pid_state_e                   state_q, state_d;
   logic signed [DATA_WIDTH-1:0] meas_q, meas_d;
   logic signed [DATA_WIDTH-1:0] sp_q, sp_d;
   logic signed [DATA_WIDTH-1:0] kp_q, kp_d;
   logic signed [DATA_WIDTH-1:0] ki_q, ki_d;
   logic signed [E_W-1:0]        err_q, err_d, err_s;
   logic signed [DL_W-1:0]       mul_a_s;
   logic signed [DATA_WIDTH-1:0] mul_b_s;
   logic signed [PR_W-1:0]       mul_s;
   logic signed [PR_W-1:0]       prod_q, prod_d;
   logic signed [PR_W-1:0]       p_term_q, p_term_d;
   logic signed [PR_W-1:0]       d_term_s;
   logic signed [S_W-1:0]        sum_s;
   logic [1:0]                   sum_flags_s;
   logic signed [OUT_WIDTH-1:0]  integ_s;
   logic signed [OUT_WIDTH-1:0]  data_out_q, data_out_d;
   logic                         out_valid_q, out_valid_d;
   logic                         busy_q, busy_d;
   logic                         overrun_q, overrun_d;
   logic                         acc_add_s;
`ifdef PID_DERIV_EN
   logic signed [DATA_WIDTH-1:0] kd_q, kd_d;
   logic signed [E_W-1:0]        prev_err_q, prev_err_d;
   logic signed [DL_W-1:0]       delta_q, delta_d;
`else
   logic                         d_coef_unused;
   assign d_coef_unused = ^d_coef;
`endif

   // Sequencing: one multiply per state, derivative step only when built in.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = ERR;
            end else begin
               state_d = IDLE;
            end
         end
         ERR:   state_d = MUL_P;
         MUL_P: state_d = MUL_I;
`ifdef PID_DERIV_EN
         MUL_I: state_d = MUL_D;
         MUL_D: state_d = SUM;
`else
         MUL_I: state_d = SUM;
`endif
         SUM:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Shared multiplier operand select; idle states multiply zero.
   always_comb begin
      mul_a_s = '0;
      mul_b_s = '0;
      case (state_q)
         MUL_P: begin
            mul_a_s = DL_W'(err_q);
            mul_b_s = kp_q;
         end
         MUL_I: begin
            mul_a_s = DL_W'(err_q);
            mul_b_s = ki_q;
         end
`ifdef PID_DERIV_EN
         MUL_D: begin
            mul_a_s = delta_q;
            mul_b_s = kd_q;
         end
`endif
         default: begin
            mul_a_s = '0;
            mul_b_s = '0;
         end
      endcase
      mul_s  = PR_W'(mul_a_s) * PR_W'(mul_b_s);
      prod_d = mul_s;
   end

   // In SUM, prod_q still holds the D product registered at the end of MUL_D.
   always_comb begin
`ifdef PID_DERIV_EN
      d_term_s = prod_q;
`else
      d_term_s = '0;
`endif
      sum_s       = S_W'(p_term_q) + S_W'(integ_s) + S_W'(d_term_s);
      sum_flags_s = sat_flags(64'(sum_s), OUT_WIDTH);
   end

   // Snapshot, error, term and output datapath.
   always_comb begin
      meas_d      = meas_q;
      sp_d        = sp_q;
      kp_d        = kp_q;
      ki_d        = ki_q;
      err_s       = E_W'(sp_q) - E_W'(meas_q);
      err_d       = err_q;
      p_term_d    = p_term_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;
      acc_add_s   = 1'b0;
`ifdef PID_DERIV_EN
      kd_d        = kd_q;
      prev_err_d  = prev_err_q;
      delta_d     = delta_q;
`endif
      if (state_q == IDLE) begin
         if (in_valid) begin
            meas_d = $signed(data_in);
            sp_d   = $signed(set_point);
            kp_d   = $signed(p_coef);
            ki_d   = $signed(i_coef);
`ifdef PID_DERIV_EN
            kd_d   = $signed(d_coef);
`endif
         end else begin
            meas_d = meas_q;
         end
      end else begin
         if (in_valid) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_q;
         end
      end
      case (state_q)
         ERR: begin
            err_d = err_s;
`ifdef PID_DERIV_EN
            delta_d = DL_W'(err_s) - DL_W'(prev_err_q);
`endif
         end
         MUL_I: begin
            p_term_d  = prod_q;
            acc_add_s = 1'b1;
         end
`ifdef PID_DERIV_EN
         MUL_D: prev_err_d = err_q;
`endif
         SUM: begin
            out_valid_d = 1'b1;
            if (sum_flags_s[1]) begin
               data_out_d = OUT_MAX;
            end else if (sum_flags_s[0]) begin
               data_out_d = OUT_MIN;
            end else begin
               data_out_d = sum_s[OUT_WIDTH-1:0];
            end
         end
         default: begin
            err_d = err_q;
         end
      endcase
   end

   pid_sat_acc #(
      .ACC_WIDTH (OUT_WIDTH),
      .ADD_WIDTH (PR_W)
   ) u_integ (
      .clk     (clk),
      .rst     (rst),
      .clear   (int_clear),
      .add_en  (acc_add_s),
      .add_val (mul_s),
      .acc     (integ_s)
   );

   // State and datapath registers; reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         meas_q      <= '0;
         sp_q        <= '0;
         kp_q        <= '0;
         ki_q        <= '0;
         err_q       <= '0;
         prod_q      <= '0;
         p_term_q    <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef PID_DERIV_EN
         kd_q        <= '0;
         prev_err_q  <= '0;
         delta_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         meas_q      <= meas_d;
         sp_q        <= sp_d;
         kp_q        <= kp_d;
         ki_q        <= ki_d;
         err_q       <= err_d;
         prod_q      <= prod_d;
         p_term_q    <= p_term_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
`ifdef PID_DERIV_EN
         kd_q        <= kd_d;
         prev_err_q  <= prev_err_d;
         delta_q     <= delta_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pid_sequencer.sv
// Directed, table-driven bench for pid_sequencer; expectations follow PID_DERIV_EN.
module tb_pid_sequencer;

   localparam int DW = 14;
   localparam int OW = 2 * DW + 1;
`ifdef PID_DERIV_EN
   localparam int LAT   = 5;
   localparam bit DERIV = 1'b1;
`else
   localparam int LAT   = 4;
   localparam bit DERIV = 1'b0;
`endif

   typedef struct {
      int     sp;
      int     din;
      int     kp;
      int     ki;
      int     kd;
      bit     clr;
      bit     rst_b;
      longint exp_pid;
      longint exp_pi;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] data_in;
   logic [DW-1:0] set_point;
   logic [DW-1:0] p_coef;
   logic [DW-1:0] i_coef;
   logic [DW-1:0] d_coef;
   logic          int_clear;
   logic          busy;
   logic [OW-1:0] data_out;
   logic          out_valid;
   logic          overrun;

   int n_checks = 0;
   int n_fail   = 0;

   pid_sequencer #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .set_point (set_point),
      .p_coef    (p_coef),
      .i_coef    (i_coef),
      .d_coef    (d_coef),
      .int_clear (int_clear),
      .busy      (busy),
      .data_out  (data_out),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   function automatic longint dout_s();
      return longint'($signed(data_out));
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      set_point = DW'(v.sp);
      data_in   = DW'(v.din);
      p_coef    = DW'(v.kp);
      i_coef    = DW'(v.ki);
      d_coef    = DW'(v.kd);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // One sample at the earliest acceptance; checks latency, busy span and result.
   task automatic run_sample(input vec_t v, input string tag);
      int n;
      int busy_n;
      if (v.rst_b) do_reset();
      if (v.clr) begin
         int_clear = 1'b1;
         @(posedge clk); #1;
         int_clear = 1'b0;
      end
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n      = 0;
      busy_n = 0;
      while (!out_valid && n < 20) begin
         if (busy) busy_n++;
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, n, LAT);
      check({tag, " busy cycles"}, busy_n, LAT);
      check({tag, " data_out"}, dout_s(), DERIV ? v.exp_pid : v.exp_pi);
   endtask

   vec_t vecs[19];
   vec_t v;
   int   n;
   int   pulses;

   initial begin
      vecs[0]  = '{100,   40,   2,    0,  0, 1'b0, 1'b0,        120,        120};
      vecs[1]  = '{10,     0,   0,    1,  0, 1'b0, 1'b0,         10,         10};
      vecs[2]  = '{10,     0,   0,    1,  0, 1'b0, 1'b0,         20,         20};
      vecs[3]  = '{10,     0,   0,    1,  0, 1'b0, 1'b0,         30,         30};
      vecs[4]  = '{10,     0,   0,    1,  0, 1'b1, 1'b0,         10,         10};
      vecs[5]  = '{8191,   0,   0, 8191,  0, 1'b1, 1'b0,   67092481,   67092481};
      vecs[6]  = '{8191,   0,   0, 8191,  0, 1'b0, 1'b0,  134184962,  134184962};
      vecs[7]  = '{8191,   0,   0, 8191,  0, 1'b0, 1'b0,  201277443,  201277443};
      vecs[8]  = '{8191,   0,   0, 8191,  0, 1'b0, 1'b0,  268369924,  268369924};
      vecs[9]  = '{8191,   0,   0, 8191,  0, 1'b0, 1'b0,  268435455,  268435455};
      vecs[10] = '{8191,   0,   0, 8191,  0, 1'b0, 1'b0,  268435455,  268435455};
      vecs[11] = '{-8192, 8191, 0, 8191,  0, 1'b1, 1'b0, -134193153, -134193153};
      vecs[12] = '{-8192, 8191, 0, 8191,  0, 1'b0, 1'b0, -268386306, -268386306};
      vecs[13] = '{-8192, 8191, 0, 8191,  0, 1'b0, 1'b0, -268435456, -268435456};
      vecs[14] = '{-8192, 8191, 0, 8191,  0, 1'b0, 1'b0, -268435456, -268435456};
      vecs[15] = '{5,      0,   0,    0,  3, 1'b0, 1'b1,         15,          0};
      vecs[16] = '{9,      0,   0,    0,  3, 1'b0, 1'b0,         12,          0};
      vecs[17] = '{50,    20,   3,    2, -1, 1'b0, 1'b1,        120,        150};
      vecs[18] = '{50,    45,   3,    2, -1, 1'b0, 1'b0,        110,         85};

      rst = 1'b1;
      in_valid = 1'b0;
      int_clear = 1'b0;
      data_in = '0;
      set_point = '0;
      p_coef = '0;
      i_coef = '0;
      d_coef = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset data_out", dout_s(), 0);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset overrun", overrun, 0);

      for (int k = 0; k < 19; k++) begin
         run_sample(vecs[k], $sformatf("vec%0d", k));
      end

      // Samples offered while busy are dropped and only flag overrun.
      do_reset();
      check("overrun after rst", overrun, 0);
      v = '{10, 0, 0, 1, 0, 1'b0, 1'b0, 10, 10};
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      set_point = DW'(-3000);
      data_in   = DW'(5000);
      repeat (3) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("overrun set", overrun, 1);
      check("data_out held while busy", dout_s(), 0);
      wait_valid(n);
      check("overrun sample latency", n, LAT - 3);
      check("overrun sample data_out", dout_s(), 10);
      @(posedge clk); #1;
      check("out_valid single pulse", out_valid, 0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("overrun sticky", overrun, 1);
      v = '{10, 0, 0, 1, 0, 1'b0, 1'b0, 20, 20};
      run_sample(v, "post-overrun");
      check("overrun still set", overrun, 1);
      do_reset();
      check("overrun cleared by rst", overrun, 0);

      // Reset landing in MUL_I aborts the sample and empties the integrator.
      v = '{10, 0, 0, 1, 0, 1'b0, 1'b0, 10, 10};
      run_sample(v, "pre-abort");
      drive(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("busy before abort", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort data_out", dout_s(), 0);
      check("abort out_valid", out_valid, 0);
      check("abort busy", busy, 0);
      check("abort overrun", overrun, 0);
      pulses = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("no pulse after abort", pulses, 0);
      run_sample(v, "post-abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
